// File: rtl/imem_loader_if.sv
// Byte stream in / instruction memory write out.
// slave: loader side; master: byte source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads 18-bit words from a byte stream into instruction memory.
// Ports: clk, reset, start, bus (stream + imem write), status outputs.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 18,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_written
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, B0, B1, B2,
    WRITE, CKSUM, DONE, ERROR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [7:0]        len_hi;
  logic [7:0]        acc;
  logic [10:0]       len;
  logic [10:0]       len_new;
  logic              len_bad;
  logic [ADDR_W:0]   ww_inc;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] word;
  logic              take;

  assign take    = bus.in_valid && bus.in_ready;
  assign len_new = {len_hi[2:0], bus.in_data};
  assign len_bad = (len_hi[7:3] != 5'd0) ||
                   (len_new == 11'd0) ||
                   (len_new > 11'd1024);
  assign ww_inc  = words_written + 1'b1;

  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = word;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, ERROR: if (start) nxt = LEN_HI;
      LEN_HI:      if (take) nxt = LEN_LO;
      LEN_LO:      if (take) nxt = len_bad ? ERROR : B0;
      B0:          if (take) nxt = B1;
      B1:          if (take) nxt = B2;
      B2:          if (take) nxt = WRITE;
      WRITE:       nxt = (ww_inc < len) ? B0 : CKSUM;
      CKSUM:
        if (take)
          nxt = (bus.in_data == acc) ? DONE : ERROR;
      DONE:        nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.imem_we   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_hold      <= 1'b0;
      words_written <= '0;
      len_hi        <= '0;
      len           <= '0;
      acc           <= '0;
      addr          <= '0;
      word          <= '0;
    end else begin
      state        <= nxt;
      bus.in_ready <= nxt inside {LEN_HI, LEN_LO,
                                  B0, B1, B2, CKSUM};
      bus.imem_we  <= (nxt == WRITE);
      busy         <= !(nxt inside {IDLE, ERROR});
      done         <= (nxt == DONE);
      error        <= (nxt == ERROR);

      if ((state inside {IDLE, ERROR}) && start) begin
        cpu_hold      <= 1'b1;
        words_written <= '0;
        acc           <= '0;
        addr          <= ADDR_W'(BASE_ADDR);
      end

      // Checksum covers everything before the CKSUM byte.
      if (take && state != CKSUM)
        acc <= acc ^ bus.in_data;

      if (take) begin
        unique case (state)
          LEN_HI:  len_hi       <= bus.in_data;
          LEN_LO:  len          <= len_new;
          B0:      word[17:16]  <= bus.in_data[1:0];
          B1:      word[15:8]   <= bus.in_data;
          B2:      word[7:0]    <= bus.in_data;
          default: ;
        endcase
      end

      if (state == WRITE) begin
        words_written <= ww_inc;
        addr          <= addr + 1'b1;
      end

      if (nxt == DONE)
        cpu_hold <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Two instances: BASE_ADDR 0 and BASE_ADDR 1000.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int DW = 18;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       sel;
  logic       vld;
  logic [7:0] dat;
  logic       st;
  int         gap;
  int         mid_start;

  imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  assign b0.in_valid = vld & !sel;
  assign b0.in_data  = dat;
  assign b1.in_valid = vld & sel;
  assign b1.in_data  = dat;

  logic h0, y0, d0, e0, h1, y1, d1, e1;
  logic [AW:0] w0, w1;

  imem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .start(st & !sel), .bus(b0),
    .cpu_hold(h0), .busy(y0), .done(d0), .error(e0),
    .words_written(w0)
  );

  imem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(1000)) u1 (
    .clk(clk), .reset(reset), .start(st & sel), .bus(b1),
    .cpu_hold(h1), .busy(y1), .done(d1), .error(e1),
    .words_written(w1)
  );

  wr_t q0[$];
  wr_t q1[$];
  int  dn0, dn1;
  int  tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy();
    return sel ? b1.in_ready : b0.in_ready;
  endfunction

  // Advance to the next falling edge and score any write seen there.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (b0.imem_we) begin
      chk("we0_in_ready", 32'(b0.in_ready), 0);
      if (q0.size() == 0) chk("q0_extra_write", 32'(q0.size()), 1);
      else begin
        e = q0.pop_front();
        chk("addr0", 32'(b0.imem_addr), 32'(e.a));
        chk("data0", 32'(b0.imem_wdata), 32'(e.d));
      end
    end
    if (b1.imem_we) begin
      chk("we1_in_ready", 32'(b1.in_ready), 0);
      if (q1.size() == 0) chk("q1_extra_write", 32'(q1.size()), 1);
      else begin
        e = q1.pop_front();
        chk("addr1", 32'(b1.imem_addr), 32'(e.a));
        chk("data1", 32'(b1.imem_wdata), 32'(e.d));
      end
    end
    if (d0) dn0++;
    if (d1) dn1++;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gap != 0 && $urandom_range(0, 2) == 0) begin
      vld = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    vld = 1'b1;
    dat = b;
    while (!rdy() && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("ready_timeout", 32'(n), 0);
    tick();
  endtask

  task automatic pulse_start();
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic load(input int base, input logic [17:0] w[$],
                      input logic [7:0] bad);
    int n = w.size();
    logic [7:0] hi, lo, c, x0, x1, x2;
    wr_t e;
    hi = 8'(n >> 8);
    lo = 8'(n);
    c  = hi ^ lo;
    send(hi);
    send(lo);
    foreach (w[i]) begin
      x0 = {6'b101100, w[i][17:16]};
      x1 = w[i][15:8];
      x2 = w[i][7:0];
      c  = c ^ x0 ^ x1 ^ x2;
      e.a = AW'(base + i);
      e.d = w[i];
      if (sel) q1.push_back(e);
      else q0.push_back(e);
      send(x0);
      if (i == 0 && mid_start != 0) st = 1'b1;
      send(x1);
      st = 1'b0;
      send(x2);
    end
    send(c ^ bad);
    vld = 1'b0;
  endtask

  task automatic check_ok0(input string tag);
    repeat (3) tick();
    chk({tag, "_done"}, 32'(dn0), 1);
    chk({tag, "_err"}, 32'(e0), 0);
    chk({tag, "_ww"}, 32'(w0), 2);
    chk({tag, "_hold"}, 32'(h0), 0);
    chk({tag, "_busy"}, 32'(y0), 0);
    chk({tag, "_pending"}, 32'(q0.size()), 0);
  endtask

  task automatic bad_len(input string tag, input logic [7:0] hi,
                         input logic [7:0] lo);
    pulse_start();
    send(hi);
    send(lo);
    vld = 1'b0;
    repeat (2) tick();
    chk({tag, "_err"}, 32'(e0), 1);
    chk({tag, "_rdy"}, 32'(b0.in_ready), 0);
    chk({tag, "_hold"}, 32'(h0), 1);
    chk({tag, "_ww"}, 32'(w0), 0);
  endtask

  logic [17:0] img[$];
  logic [17:0] big[$];

  initial begin
    tests = 0; fails = 0;
    dn0 = 0; dn1 = 0;
    sel = 1'b0; vld = 1'b0; dat = '0; st = 1'b0;
    gap = 0; mid_start = 0;
    img = '{18'h12345, 18'h2ABCD};
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_hold", 32'(h0), 0);
    chk("rst_busy", 32'(y0), 0);
    chk("rst_err", 32'(e0), 0);
    chk("rst_ww", 32'(w0), 0);
    chk("rst_rdy", 32'(b0.in_ready), 0);
    chk("rst_we", 32'(b0.imem_we), 0);
    chk("rst_addr", 32'(b0.imem_addr), 0);
    reset = 1'b0;
    tick();

    pulse_start();
    chk("s1_busy", 32'(y0), 1);
    chk("s1_hold", 32'(h0), 1);
    chk("s1_rdy", 32'(b0.in_ready), 1);
    load(0, img, 8'h00);
    check_ok0("s1");

    dn0 = 0;
    pulse_start();
    load(0, img, 8'hFE);
    repeat (3) tick();
    chk("s2_err", 32'(e0), 1);
    chk("s2_done", 32'(dn0), 0);
    chk("s2_hold", 32'(h0), 1);
    chk("s2_busy", 32'(y0), 0);
    chk("s2_ww", 32'(w0), 2);
    chk("s2_pending", 32'(q0.size()), 0);

    bad_len("s3_len0", 8'h00, 8'h00);
    bad_len("s3_hibits", 8'h08, 8'h00);
    bad_len("s3_len1025", 8'h04, 8'h01);

    dn0 = 0;
    mid_start = 1;
    pulse_start();
    chk("s5_err_clr", 32'(e0), 0);
    load(0, img, 8'h00);
    check_ok0("s5_cont");

    dn0 = 0;
    gap = 1;
    pulse_start();
    load(0, img, 8'h00);
    check_ok0("s5_gap");
    gap = 0;
    mid_start = 0;

    pulse_start();
    send(8'h00);
    send(8'h02);
    send(8'h01);
    send(8'h23);
    #2 reset = 1'b1;
    vld = 1'b0;
    #1;
    chk("s6_hold", 32'(h0), 0);
    chk("s6_busy", 32'(y0), 0);
    chk("s6_err", 32'(e0), 0);
    chk("s6_done", 32'(d0), 0);
    chk("s6_ww", 32'(w0), 0);
    chk("s6_rdy", 32'(b0.in_ready), 0);
    chk("s6_we", 32'(b0.imem_we), 0);
    tick();
    reset = 1'b0;
    tick();
    dn0 = 0;
    pulse_start();
    load(0, img, 8'h00);
    check_ok0("s6_reload");

    sel = 1'b1;
    for (int i = 0; i < 1024; i++) big.push_back(18'($urandom));
    pulse_start();
    load(1000, big, 8'h00);
    repeat (3) tick();
    chk("s4_done", 32'(dn1), 1);
    chk("s4_err", 32'(e1), 0);
    chk("s4_ww", 32'(w1), 1024);
    chk("s4_hold", 32'(h1), 0);
    chk("s4_pending", 32'(q1.size()), 0);
    chk("s4_other_ww", 32'(w0), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the 18-bit instruction memory that the CPU fetches from.
- Receives a byte stream over a valid/ready interface, assembles 18-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU off (cpu_hold) for the whole load.
- Sits between the host/UART byte source and the instruction memory write port; the top level gates CPU reset with cpu_hold.

Parameters:
- ADDR_W, 10, instruction memory address width (1024 words).
- DATA_W, 18, instruction word width; the byte-assembly rules below are fixed for 18.
- BASE_ADDR, 0, address of the first word written; higher addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begins a load when the block is in IDLE or ERROR.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  block can accept a byte this cycle.
- imem_we  output  1  one-cycle instruction memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  write data.
- cpu_hold  output  1  CPU must be held in reset while high.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky load failure.
- words_written  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset (asynchronous): state IDLE; every output 0, including cpu_hold, error and words_written. Reset mid-load aborts the load immediately. Memory writes already performed are not undone.
- Byte transfer occurs on any rising edge where in_valid && in_ready. in_ready=1 only in LEN_HI, LEN_LO, B0, B1, B2 and CKSUM; it is 0 in every other state.
- Stream format: LEN_HI, LEN_LO, then LEN groups of three bytes (B0, B1, B2), then CKSUM.
- States: IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CKSUM, DONE, ERROR.
- IDLE/ERROR + start: go to LEN_HI. Clear error, words_written and the checksum accumulator. Set cpu_hold=1 and busy=1. start in any other state is ignored.
- Length: len = {LEN_HI[2:0], LEN_LO}, 11 bits.
  - Go to ERROR if LEN_HI[7:3] != 0, len == 0, or len > 1024.
  - The check is made when LEN_LO is accepted; the next state is then ERROR, otherwise B0.
- Word assembly: word = {B0[1:0], B1, B2}. B0[7:2] is ignored but still included in the checksum.
- WRITE is entered the cycle after B2 is accepted. It lasts exactly one cycle:
  - imem_we=1, imem_addr = (BASE_ADDR + index) mod 2^ADDR_W, imem_wdata = word.
  - words_written increments at the end of the cycle.
  - Next state is B0 if words_written+1 < len, otherwise CKSUM.
- imem_addr and imem_wdata are don't-care when imem_we=0.
- Throughput: at most one word per 4 cycles.
- Checksum: XOR of every accepted byte from LEN_HI through the last B2. On CKSUM accept:
  - If the byte equals the accumulator, go to DONE.
  - Otherwise go to ERROR.
- DONE (one cycle): done=1, cpu_hold goes to 0, busy goes to 0, then IDLE.
- ERROR:
  - error=1, busy=0, cpu_hold stays 1 so the CPU never runs a corrupt image.
  - The state is left only by start or reset.
- in_valid held high with no handshake is never double-counted. Bytes offered while in_ready=0 must be held by the source and are not lost.
- Signal relations:
  - busy=1 in all states except IDLE and ERROR.
  - cpu_hold=1 from start acceptance until DONE, and through ERROR.

Test Plan:
1. Two-word load, BASE_ADDR=0: start; bytes 00,02, 01,23,45, 02,AB,CD, 01 (correct XOR) -> writes addr0=0x12345, addr1=0x2ABCD. done pulses once. error=0, words_written=2, cpu_hold returns to 0 after done.
2. Same stream with checksum byte FF -> both writes still occur. error=1, done never asserted, cpu_hold stays 1. A subsequent start clears error.
3. Length 00,00 (and separately 08,00, and 04,01) -> ERROR after LEN_LO. No imem_we, in_ready=0 thereafter, cpu_hold=1.
4. BASE_ADDR=1000, len=04,00 (1024 words) -> writes at addresses 1000..1023 then 0..999. words_written=1024; done on correct checksum.
5. Backpressure: in_valid held high continuously and with random gaps -> in_ready=0 during every WRITE cycle. Each byte is consumed exactly once and the image matches scenario 1. start pulsed mid-load is ignored.
6. Reset asserted asynchronously after 4 bytes of scenario 1 -> all outputs 0 immediately. A fresh start with the full scenario 1 stream then completes correctly.
